// File: rtl/rt_mu_ctrl_pkg.sv
// Shared types and default geometry for the racetrack memory-unit controller.
package rt_mu_ctrl_pkg;

   localparam int unsigned NR_DEF  = 4;
   localparam int unsigned NB_DEF  = 32;
   localparam int unsigned NP_DEF  = 8;
   localparam int unsigned NSP_DEF = NB_DEF / NP_DEF;

   typedef enum logic [1:0] {
      OP_RD      = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_WR_MASK = 2'b10,
      OP_LIM     = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT_S = 3'd1,
      ST_SHIFT_M = 3'd2,
      ST_ACCESS  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Ops that sample the MU read data at the end of ACCESS.
   function automatic logic op_is_read(input op_e op);
      return (op == OP_RD) || (op == OP_LIM);
   endfunction

endpackage

// File: rtl/rt_wl_decoder.sv
// Address-to-one-hot word-line decoder; all lines low when disabled.
module rt_wl_decoder #(
   parameter int unsigned NB = 32
) (
   input  logic [$clog2(NB)-1:0] addr_i,
   input  logic                  en_i,
   output logic [NB-1:0]         wl_c
);

   // One-hot decode gated by enable.
   always_comb begin
      wl_c = '0;
      if (en_i) wl_c = NB'(1) << addr_i;
   end

endmodule

// File: rtl/rt_mu_ctrl.sv
// Racetrack memory-unit controller: shifts the track to the addressed port
// position, performs one access cycle, then reports completion.
// Optional feature macro: RT_MU_CTRL_LIM_EN enables logic-in-memory reads (op 11);
// without it op 11 executes as a plain read.
module rt_mu_ctrl
   import rt_mu_ctrl_pkg::*;
#(
   parameter int unsigned NR = NR_DEF,
   parameter int unsigned NB = NB_DEF,
   parameter int unsigned NP = NP_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_i,
   input  logic [1:0]            op_i,
   input  logic [$clog2(NB)-1:0] addr_i,
   input  logic [NR-1:0]         wdata_i,
   input  logic                  nand_norn_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [NR-1:0]         rdata_o,
   output logic                  busy_o,
   output logic [NB-1:0]         word_lines_o,
   output logic [NR-1:0]         write_i_data_o,
   output logic                  write_en_data_o,
   output logic [NR-1:0]         write_i_mask_o,
   output logic                  write_en_mask_o,
   output logic                  read_current_o,
   output logic                  out_select_o,
   output logic                  in1_nand_norn_o,
   output logic                  current_s_o,
   output logic                  current_m_o,
   output logic                  bz_s_o,
   output logic                  bz_m_o,
   input  logic [NR-1:0]         mu_rdata_i
);

   localparam int unsigned NSP = NB / NP;
   localparam int unsigned AW  = $clog2(NB);
   localparam int unsigned PW  = (NSP > 1) ? $clog2(NSP) : 1;

   state_e          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   op_e             op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [NR-1:0]   wdata_q, wdata_d;
   logic            nn_q, nn_d;
   logic [NR-1:0]   rdata_q, rdata_d;
   logic [PW-1:0]   k_c;

   logic            acc_d, lim_d;
   logic [NB-1:0]   wl_c;
   logic [NB-1:0]   wl_q;
   logic [NR-1:0]   wi_data_q, wi_data_d, wi_mask_q, wi_mask_d;
   logic            wen_data_q, wen_data_d, wen_mask_q, wen_mask_d;
   logic            rd_cur_q, rd_cur_d, osel_q, osel_d, in1_q, in1_d;
   logic            cur_s_q, cur_s_d, cur_m_q, cur_m_d, bz_q, bz_d;
   logic            rvalid_q, rvalid_d, busy_q, busy_d;

   assign gnt_o = req_i && (state_q == ST_IDLE);
   assign k_c   = addr_i[PW-1:0] - pos_q;

   // Next-state, request capture, track position and read-data capture.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      nn_d    = nn_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_o) begin
               op_d    = op_e'(op_i);
               addr_d  = addr_i;
               wdata_d = wdata_i;
               nn_d    = nand_norn_i;
               if (k_c != '0) begin
                  cnt_d   = k_c;
                  state_d = ST_SHIFT_S;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_SHIFT_S: state_d = ST_SHIFT_M;
         ST_SHIFT_M: begin
            pos_d   = pos_q + PW'(1);
            cnt_d   = cnt_q - PW'(1);
            state_d = (cnt_q == PW'(1)) ? ST_ACCESS : ST_SHIFT_S;
         end
         ST_ACCESS: begin
            if (op_is_read(op_q)) rdata_d = mu_rdata_i;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   rt_wl_decoder #(.NB(NB)) u_wl_dec (
      .addr_i (addr_d),
      .en_i   (acc_d),
      .wl_c   (wl_c)
   );

   // Output decode from the upcoming state so every output is a flop aligned with its state.
   always_comb begin
      acc_d = (state_d == ST_ACCESS);
`ifdef RT_MU_CTRL_LIM_EN
      lim_d = acc_d && (op_d == OP_LIM);
`else
      lim_d = 1'b0;
`endif
      rd_cur_d   = acc_d && op_is_read(op_d);
      osel_d     = lim_d;
      bz_d       = lim_d;
      in1_d      = lim_d & nn_d;
      wen_data_d = acc_d && (op_d == OP_WR_DATA);
      wen_mask_d = acc_d && (op_d == OP_WR_MASK);
      wi_data_d  = wen_data_d ? wdata_d : '0;
      wi_mask_d  = wen_mask_d ? wdata_d : '0;
      cur_s_d    = (state_d == ST_SHIFT_S);
      cur_m_d    = (state_d == ST_SHIFT_M);
      rvalid_d   = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         pos_q      <= '0;
         cnt_q      <= '0;
         op_q       <= OP_RD;
         addr_q     <= '0;
         wdata_q    <= '0;
         nn_q       <= 1'b0;
         rdata_q    <= '0;
         wl_q       <= '0;
         wi_data_q  <= '0;
         wi_mask_q  <= '0;
         wen_data_q <= 1'b0;
         wen_mask_q <= 1'b0;
         rd_cur_q   <= 1'b0;
         osel_q     <= 1'b0;
         in1_q      <= 1'b0;
         cur_s_q    <= 1'b0;
         cur_m_q    <= 1'b0;
         bz_q       <= 1'b0;
         rvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         nn_q       <= nn_d;
         rdata_q    <= rdata_d;
         wl_q       <= wl_c;
         wi_data_q  <= wi_data_d;
         wi_mask_q  <= wi_mask_d;
         wen_data_q <= wen_data_d;
         wen_mask_q <= wen_mask_d;
         rd_cur_q   <= rd_cur_d;
         osel_q     <= osel_d;
         in1_q      <= in1_d;
         cur_s_q    <= cur_s_d;
         cur_m_q    <= cur_m_d;
         bz_q       <= bz_d;
         rvalid_q   <= rvalid_d;
         busy_q     <= busy_d;
      end
   end

   assign rvalid_o        = rvalid_q;
   assign rdata_o         = rdata_q;
   assign busy_o          = busy_q;
   assign word_lines_o    = wl_q;
   assign write_i_data_o  = wi_data_q;
   assign write_en_data_o = wen_data_q;
   assign write_i_mask_o  = wi_mask_q;
   assign write_en_mask_o = wen_mask_q;
   assign read_current_o  = rd_cur_q;
   assign out_select_o    = osel_q;
   assign in1_nand_norn_o = in1_q;
   assign current_s_o     = cur_s_q;
   assign current_m_o     = cur_m_q;
   assign bz_s_o          = bz_q;
   assign bz_m_o          = bz_q;

endmodule

// File: tb/tb_rt_mu_ctrl.sv
// Directed self-checking bench for rt_mu_ctrl with an expected-read-data scoreboard.
module tb_rt_mu_ctrl;

   localparam int unsigned NR  = 4;
   localparam int unsigned NB  = 32;
   localparam int unsigned NSP = 4;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          req_i = 1'b0;
   logic [1:0]    op_i = '0;
   logic [4:0]    addr_i = '0;
   logic [NR-1:0] wdata_i = '0;
   logic          nand_norn_i = 1'b0;
   logic [NR-1:0] mu_rdata_i = '0;
   logic          gnt_o, rvalid_o, busy_o;
   logic [NR-1:0] rdata_o;
   logic [NB-1:0] word_lines_o;
   logic [NR-1:0] write_i_data_o, write_i_mask_o;
   logic          write_en_data_o, write_en_mask_o, read_current_o, out_select_o;
   logic          in1_nand_norn_o, current_s_o, current_m_o, bz_s_o, bz_m_o;

   int            n_assert = 0;
   int            n_fail = 0;
   logic [NR-1:0] sb_q[$];
   logic [1:0]    pos_m = '0;
   logic [NR-1:0] rdata_m = '0;

   always #5 clk_i = ~clk_i;

   rt_mu_ctrl dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .nand_norn_i(nand_norn_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .busy_o(busy_o), .word_lines_o(word_lines_o),
      .write_i_data_o(write_i_data_o), .write_en_data_o(write_en_data_o),
      .write_i_mask_o(write_i_mask_o), .write_en_mask_o(write_en_mask_o),
      .read_current_o(read_current_o), .out_select_o(out_select_o),
      .in1_nand_norn_o(in1_nand_norn_o), .current_s_o(current_s_o),
      .current_m_o(current_m_o), .bz_s_o(bz_s_o), .bz_m_o(bz_m_o),
      .mu_rdata_i(mu_rdata_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every DUT output except gnt/rdata bundled for idle/reset checks.
   function automatic logic [63:0] all_outs();
      return {rvalid_o, busy_o, word_lines_o, write_i_data_o, write_en_data_o,
              write_i_mask_o, write_en_mask_o, read_current_o, out_select_o,
              in1_nand_norn_o, current_s_o, current_m_o, bz_s_o, bz_m_o};
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [4:0] addr, input logic [NR-1:0] wd,
                        input logic nn, input logic [NR-1:0] mu, input logic hold);
      int            k, n, w, s_cnt, m_cnt;
      logic          is_rd, lim, done;
      logic [NR-1:0] exp_rd;
      logic [NB-1:0] oh;
      k      = (int'(addr[1:0]) - int'(pos_m) + NSP) % NSP;
      is_rd  = (op == 2'b00) || (op == 2'b11);
`ifdef RT_MU_CTRL_LIM_EN
      lim    = (op == 2'b11);
`else
      lim    = 1'b0;
`endif
      exp_rd = is_rd ? mu : rdata_m;
      oh     = NB'(1) << addr;
      @(negedge clk_i);
      req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd; nand_norn_i = nn; mu_rdata_i = mu;
      #1;
      w = 0;
      while (!gnt_o && w < 50) begin
         @(negedge clk_i); #1; w++;
      end
      chk("grant", 64'(gnt_o), 64'd1);
      if (!gnt_o) begin
         req_i = 1'b0;
         return;
      end
      sb_q.push_back(exp_rd);
      @(posedge clk_i); #1;
      if (!hold) req_i = 1'b0;
      n = 1; s_cnt = 0; m_cnt = 0; done = 1'b0;
      while (!done && n < 60) begin
         chk("word_lines", 64'(word_lines_o), (n == 1 + 2 * k) ? 64'(oh) : 64'd0);
         if (n == 1 + 2 * k) begin
            chk("read_current", 64'(read_current_o), 64'(is_rd));
            chk("out_select", 64'(out_select_o), 64'(lim));
            chk("bz_s", 64'(bz_s_o), 64'(lim));
            chk("bz_m", 64'(bz_m_o), 64'(lim));
            chk("in1_nand_norn", 64'(in1_nand_norn_o), 64'(lim & nn));
            chk("wen_data", 64'(write_en_data_o), 64'(op == 2'b01));
            chk("wi_data", 64'(write_i_data_o), (op == 2'b01) ? 64'(wd) : 64'd0);
            chk("wen_mask", 64'(write_en_mask_o), 64'(op == 2'b10));
            chk("wi_mask", 64'(write_i_mask_o), (op == 2'b10) ? 64'(wd) : 64'd0);
         end else begin
            chk("wr_idle", 64'({write_en_data_o, write_en_mask_o, write_i_data_o, write_i_mask_o}), 64'd0);
         end
         chk("busy", 64'(busy_o), 64'd1);
         if (hold) chk("gnt_while_busy", 64'(gnt_o), 64'd0);
         s_cnt += int'(current_s_o);
         m_cnt += int'(current_m_o);
         if (rvalid_o) begin
            chk("latency", 64'(n), 64'(2 + 2 * k));
            chk("rdata", 64'(rdata_o), 64'(sb_q.pop_front()));
            done  = 1'b1;
            req_i = 1'b0;
         end else begin
            @(posedge clk_i); #1; n++;
         end
      end
      chk("rvalid_seen", 64'(done), 64'd1);
      chk("shift_s_count", 64'(s_cnt), 64'(k));
      chk("shift_m_count", 64'(m_cnt), 64'(k));
      @(posedge clk_i); #1;
      chk("idle_after_done", all_outs(), 64'd0);
      pos_m   = addr[1:0];
      rdata_m = exp_rd;
   endtask

   initial begin
      int rv_seen, w;
      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_outs", all_outs(), 64'd0);
      chk("reset_rdata", 64'(rdata_o), 64'd0);
      chk("reset_gnt", 64'(gnt_o), 64'd0);
      @(negedge clk_i); rstn_i = 1'b1;

      do_op(2'b00, 5'd8,  4'h0, 1'b0, 4'hA, 1'b0);   // RD k=0
      do_op(2'b01, 5'd3,  4'h5, 1'b0, 4'hF, 1'b0);   // WR data k=3
      do_op(2'b00, 5'd1,  4'h0, 1'b0, 4'h7, 1'b1);   // RD k=2 with wrap, req held
      do_op(2'b10, 5'd6,  4'hC, 1'b0, 4'h2, 1'b0);   // WR mask k=1
      do_op(2'b11, 5'd31, 4'h0, 1'b1, 4'h3, 1'b0);   // LIM k=1
      do_op(2'b00, 5'd0,  4'h0, 1'b0, 4'h6, 1'b0);   // RD k=1, wrap 3->0

      // Abort mid-shift with reset: no rvalid, position and rdata cleared.
      @(negedge clk_i);
      req_i = 1'b1; op_i = 2'b00; addr_i = 5'd3; mu_rdata_i = 4'h4;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      w = 0;
      while (!current_m_o && w < 20) begin
         @(posedge clk_i); #1; w++;
      end
      chk("reached_shift_m", 64'(current_m_o), 64'd1);
      rstn_i = 1'b0;
      @(posedge clk_i); #1;
      chk("abort_outs", all_outs(), 64'd0);
      chk("abort_rdata", 64'(rdata_o), 64'd0);
      rstn_i = 1'b1;
      rv_seen = 0;
      repeat (10) begin
         @(posedge clk_i); #1;
         rv_seen += int'(rvalid_o);
      end
      chk("no_rvalid_after_abort", 64'(rv_seen), 64'd0);
      pos_m = '0; rdata_m = '0;

      do_op(2'b00, 5'd8,  4'h0, 1'b0, 4'h9, 1'b0);   // pos back at 0: k=0
      do_op(2'b01, 5'd2,  4'h1, 1'b0, 4'h5, 1'b0);   // WR keeps rdata, k=2

      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
